// File: rtl/axi4_sram_slave.sv
// AXI4 slave in front of a single-port 64-bit SRAM. It handles one transaction at a time,
// supports INCR/FIXED/WRAP bursts, and decodes every beat address on its own.
module axi4_sram_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_axi_aw_valid,
  output logic                o_axi_aw_ready,
  input  logic [ADDR_W-1:0]   i_axi_aw_addr,
  input  logic [ID_W-1:0]     i_axi_aw_id,
  input  logic [7:0]          i_axi_aw_len,
  input  logic [2:0]          i_axi_aw_size,
  input  logic [1:0]          i_axi_aw_burst,
  input  logic                i_axi_w_valid,
  output logic                o_axi_w_ready,
  input  logic [DATA_W-1:0]   i_axi_w_data,
  input  logic [DATA_W/8-1:0] i_axi_w_strb,
  input  logic                i_axi_w_last,
  output logic                o_axi_b_valid,
  input  logic                i_axi_b_ready,
  output logic [1:0]          o_axi_b_resp,
  output logic [ID_W-1:0]     o_axi_b_id,
  input  logic                i_axi_ar_valid,
  output logic                o_axi_ar_ready,
  input  logic [ADDR_W-1:0]   i_axi_ar_addr,
  input  logic [ID_W-1:0]     i_axi_ar_id,
  input  logic [7:0]          i_axi_ar_len,
  input  logic [2:0]          i_axi_ar_size,
  input  logic [1:0]          i_axi_ar_burst,
  output logic                o_axi_r_valid,
  input  logic                i_axi_r_ready,
  output logic [DATA_W-1:0]   o_axi_r_data,
  output logic [1:0]          o_axi_r_resp,
  output logic                o_axi_r_last,
  output logic [ID_W-1:0]     o_axi_r_id
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_DEPTH * 8);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  function automatic logic [ADDR_W-1:0] f_align(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
    return a & ~((ADDR_W'(1) << sz) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                               input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_W-1:0] step, wmask;
    step  = ADDR_W'(1) << sz;
    wmask = ((ADDR_W'(len) + ADDR_W'(1)) << sz) - ADDR_W'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~wmask) | ((a + step) & wmask);
      default: return a + step;
    endcase
  endfunction

  function automatic logic f_supported(input logic [2:0] sz, input logic [7:0] len, input logic [1:0] burst);
    case (burst)
      2'b00, 2'b01: return sz <= 3'd3;
      2'b10:        return (sz <= 3'd3) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len, r_beat;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_unsup, r_err_last, r_err_range;
  logic                r_rvalid, r_rlast;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic [ID_W-1:0]     r_rid;
  logic                w_ar_hs, w_aw_hs, w_w_hs, w_r_hs;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_rd_sup, w_rd_inr;
  logic [DATA_W-1:0]   w_rd_word;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Handshake outputs are forced low while reset is asserted
  always_comb begin
    w_state_nxt    = r_state;
    o_axi_ar_ready = 1'b0;
    o_axi_aw_ready = 1'b0;
    o_axi_w_ready  = 1'b0;
    o_axi_b_valid  = 1'b0;
    o_axi_b_resp   = RESP_OKAY;
    o_axi_b_id     = '0;
    if (!i_rst) begin
      case (r_state)
        IDLE: begin
          o_axi_ar_ready = 1'b1;
          o_axi_aw_ready = !i_axi_ar_valid;
          if (i_axi_ar_valid)      w_state_nxt = RDATA;
          else if (i_axi_aw_valid) w_state_nxt = WDATA;
        end
        WDATA: begin
          o_axi_w_ready = 1'b1;
          if (i_axi_w_valid && r_beat == r_len) w_state_nxt = WRESP;
        end
        WRESP: begin
          o_axi_b_valid = 1'b1;
          o_axi_b_id    = r_id;
          o_axi_b_resp  = (r_unsup || r_err_last) ? RESP_SLVERR :
                          r_err_range             ? RESP_DECERR : RESP_OKAY;
          if (i_axi_b_ready) w_state_nxt = IDLE;
        end
        RDATA: begin
          if (r_rvalid && i_axi_r_ready && r_rlast) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_ar_hs = o_axi_ar_ready && i_axi_ar_valid;
  assign w_aw_hs = o_axi_aw_ready && i_axi_aw_valid;
  assign w_w_hs  = o_axi_w_ready && i_axi_w_valid;
  assign w_r_hs  = r_rvalid && i_axi_r_ready;

  // Address of the beat to load next: beat 0 straight from AR, later beats from the running address
  assign w_rd_addr = (r_state == IDLE) ? f_align(i_axi_ar_addr, i_axi_ar_size)
                                       : f_next(r_addr, r_size, r_len, r_burst);
  assign w_rd_sup  = (r_state == IDLE) ? f_supported(i_axi_ar_size, i_axi_ar_len, i_axi_ar_burst)
                                       : !r_unsup;
  assign w_rd_inr  = f_in_range(w_rd_addr);
  assign w_rd_word = r_mem[f_index(w_rd_addr)];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_rlast     <= 1'b0;
      r_rid       <= '0;
      r_beat      <= '0;
      r_unsup     <= 1'b0;
      r_err_last  <= 1'b0;
      r_err_range <= 1'b0;
    end else if (w_ar_hs) begin
      r_id     <= i_axi_ar_id;
      r_addr   <= w_rd_addr;
      r_len    <= i_axi_ar_len;
      r_size   <= i_axi_ar_size;
      r_burst  <= i_axi_ar_burst;
      r_unsup  <= !w_rd_sup;
      r_beat   <= '0;
      r_rvalid <= 1'b1;
      r_rid    <= i_axi_ar_id;
      r_rlast  <= (i_axi_ar_len == 8'd0);
      r_rdata  <= (w_rd_sup && w_rd_inr) ? w_rd_word : '0;
      r_rresp  <= !w_rd_sup ? RESP_SLVERR : (w_rd_inr ? RESP_OKAY : RESP_DECERR);
    end else if (w_aw_hs) begin
      r_id        <= i_axi_aw_id;
      r_addr      <= f_align(i_axi_aw_addr, i_axi_aw_size);
      r_len       <= i_axi_aw_len;
      r_size      <= i_axi_aw_size;
      r_burst     <= i_axi_aw_burst;
      r_unsup     <= !f_supported(i_axi_aw_size, i_axi_aw_len, i_axi_aw_burst);
      r_beat      <= '0;
      r_err_last  <= 1'b0;
      r_err_range <= 1'b0;
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rvalid <= 1'b0;
      end else begin
        r_beat  <= r_beat + 8'd1;
        r_addr  <= w_rd_addr;
        r_rlast <= (r_beat + 8'd1 == r_len);
        r_rdata <= (w_rd_sup && w_rd_inr) ? w_rd_word : '0;
        r_rresp <= !w_rd_sup ? RESP_SLVERR : (w_rd_inr ? RESP_OKAY : RESP_DECERR);
      end
    end else if (w_w_hs) begin
      if (!f_in_range(r_addr))                  r_err_range <= 1'b1;
      if (i_axi_w_last != (r_beat == r_len))    r_err_last  <= 1'b1;
      r_beat <= r_beat + 8'd1;
      r_addr <= f_next(r_addr, r_size, r_len, r_burst);
    end
  end

  // Byte-lane write into the array; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_w_hs && !r_unsup && f_in_range(r_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_axi_w_strb[b]) r_mem[f_index(r_addr)][8*b +: 8] <= i_axi_w_data[8*b +: 8];
      end
    end
  end

  assign o_axi_r_valid = r_rvalid;
  assign o_axi_r_data  = r_rdata;
  assign o_axi_r_resp  = r_rresp;
  assign o_axi_r_last  = r_rlast;
  assign o_axi_r_id    = r_rid;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Bench for axi4_sram_slave: a table of transactions checked against a shadow memory model
// with R/B scoreboards, plus hand-written sequences for AR/AW collision and mid-burst reset.
module tb_axi4_sram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_axi_aw_valid = 0, o_axi_aw_ready;
  logic [31:0] i_axi_aw_addr = 0;
  logic [3:0]  i_axi_aw_id = 0;
  logic [7:0]  i_axi_aw_len = 0;
  logic [2:0]  i_axi_aw_size = 0;
  logic [1:0]  i_axi_aw_burst = 0;
  logic        i_axi_w_valid = 0, o_axi_w_ready;
  logic [63:0] i_axi_w_data = 0;
  logic [7:0]  i_axi_w_strb = 0;
  logic        i_axi_w_last = 0;
  logic        o_axi_b_valid, i_axi_b_ready = 0;
  logic [1:0]  o_axi_b_resp;
  logic [3:0]  o_axi_b_id;
  logic        i_axi_ar_valid = 0, o_axi_ar_ready;
  logic [31:0] i_axi_ar_addr = 0;
  logic [3:0]  i_axi_ar_id = 0;
  logic [7:0]  i_axi_ar_len = 0;
  logic [2:0]  i_axi_ar_size = 0;
  logic [1:0]  i_axi_ar_burst = 0;
  logic        o_axi_r_valid, i_axi_r_ready = 0;
  logic [63:0] o_axi_r_data;
  logic [1:0]  o_axi_r_resp;
  logic        o_axi_r_last;
  logic [3:0]  o_axi_r_id;

  always #5 i_clk = ~i_clk;

  axi4_sram_slave dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_axi_aw_valid(i_axi_aw_valid), .o_axi_aw_ready(o_axi_aw_ready), .i_axi_aw_addr(i_axi_aw_addr),
    .i_axi_aw_id(i_axi_aw_id), .i_axi_aw_len(i_axi_aw_len), .i_axi_aw_size(i_axi_aw_size),
    .i_axi_aw_burst(i_axi_aw_burst),
    .i_axi_w_valid(i_axi_w_valid), .o_axi_w_ready(o_axi_w_ready), .i_axi_w_data(i_axi_w_data),
    .i_axi_w_strb(i_axi_w_strb), .i_axi_w_last(i_axi_w_last),
    .o_axi_b_valid(o_axi_b_valid), .i_axi_b_ready(i_axi_b_ready), .o_axi_b_resp(o_axi_b_resp),
    .o_axi_b_id(o_axi_b_id),
    .i_axi_ar_valid(i_axi_ar_valid), .o_axi_ar_ready(o_axi_ar_ready), .i_axi_ar_addr(i_axi_ar_addr),
    .i_axi_ar_id(i_axi_ar_id), .i_axi_ar_len(i_axi_ar_len), .i_axi_ar_size(i_axi_ar_size),
    .i_axi_ar_burst(i_axi_ar_burst),
    .o_axi_r_valid(o_axi_r_valid), .i_axi_r_ready(i_axi_r_ready), .o_axi_r_data(o_axi_r_data),
    .o_axi_r_resp(o_axi_r_resp), .o_axi_r_last(o_axi_r_last), .o_axi_r_id(o_axi_r_id)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [63:0] seed;
    logic [7:0]  strb0;
    logic [7:0]  strbn;
    bit          early;
    bit          toggle;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;

  int          checks = 0, failures = 0;
  logic [63:0] model [DEPTH];
  rexp_t       rq[$];
  bexp_t       bq[$];
  vec_t        vecs[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference addressing: WRAP beats are offsets modulo the wrap window from its lower bound
  function automatic logic [31:0] beat_addr(input vec_t v, input int k);
    logic [31:0] step, a0, total, lower;
    step = 32'd1 << v.size;
    a0   = v.addr - (v.addr % step);
    case (v.burst)
      2'b00: return a0;
      2'b10: begin
        total = (32'(v.len) + 32'd1) * step;
        lower = (a0 / total) * total;
        return lower + ((a0 - lower + 32'(k) * step) % total);
      end
      default: return a0 + 32'(k) * step;
    endcase
  endfunction

  function automatic bit supported(input vec_t v);
    if (v.size > 3) return 0;
    if (v.burst == 2'b00 || v.burst == 2'b01) return 1;
    if (v.burst == 2'b10) return (v.len == 1 || v.len == 3 || v.len == 7 || v.len == 15);
    return 0;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH * 8);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic push_read(input vec_t v);
    for (int k = 0; k <= int'(v.len); k++) begin
      logic [31:0] a;
      rexp_t e;
      a = beat_addr(v, k);
      if (!supported(v))   e.resp = 2'b10;
      else if (!in_rng(a)) e.resp = 2'b11;
      else                 e.resp = 2'b00;
      e.data = (e.resp == 2'b00) ? model[widx(a)] : 64'd0;
      e.last = (k == int'(v.len));
      e.id   = v.id;
      rq.push_back(e);
    end
  endtask

  task automatic ar_phase(input vec_t v);
    int t = 0;
    i_axi_ar_addr = v.addr; i_axi_ar_len = v.len; i_axi_ar_size = v.size;
    i_axi_ar_burst = v.burst; i_axi_ar_id = v.id; i_axi_ar_valid = 1;
    #1;
    while (!o_axi_ar_ready && t < 50) begin @(negedge i_clk); #1; t++; end
    chk("ar_ready", o_axi_ar_ready, 1);
    @(negedge i_clk);
    i_axi_ar_valid = 0;
    chk("r_latency", o_axi_r_valid, 1);
  endtask

  task automatic r_phase(input bit toggle);
    int          cyc = 0;
    bit          held_v = 0;
    logic [63:0] hd;
    logic [1:0]  hr;
    logic        hl;
    rexp_t       e;
    while (rq.size() > 0 && cyc < 2000) begin
      i_axi_r_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (o_axi_r_valid && i_axi_r_ready) begin
        if (held_v) begin
          chk("r_stable_data", o_axi_r_data, hd);
          chk("r_stable_resp", o_axi_r_resp, hr);
          chk("r_stable_last", o_axi_r_last, hl);
          held_v = 0;
        end
        e = rq.pop_front();
        chk("r_data", o_axi_r_data, e.data);
        chk("r_resp", o_axi_r_resp, e.resp);
        chk("r_last", o_axi_r_last, e.last);
        chk("r_id", o_axi_r_id, e.id);
      end else if (o_axi_r_valid) begin
        held_v = 1; hd = o_axi_r_data; hr = o_axi_r_resp; hl = o_axi_r_last;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_axi_r_ready = 0;
    chk("r_beats_left", 64'(rq.size()), 0);
    chk("r_valid_end", o_axi_r_valid, 0);
  endtask

  task automatic run_read(input vec_t v);
    push_read(v);
    ar_phase(v);
    r_phase(v.toggle);
  endtask

  task automatic run_write(input vec_t v);
    int    t;
    bexp_t be;
    for (int k = 0; k <= int'(v.len); k++) begin
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      a = beat_addr(v, k);
      d = v.seed * 64'(k + 1);
      s = (k == 0) ? v.strb0 : v.strbn;
      if (supported(v) && in_rng(a))
        for (int b = 0; b < 8; b++) if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
    be.resp = v.exp_resp; be.id = v.id;
    bq.push_back(be);
    // AW
    t = 0;
    i_axi_aw_addr = v.addr; i_axi_aw_len = v.len; i_axi_aw_size = v.size;
    i_axi_aw_burst = v.burst; i_axi_aw_id = v.id; i_axi_aw_valid = 1;
    #1;
    while (!o_axi_aw_ready && t < 50) begin @(negedge i_clk); #1; t++; end
    chk("aw_ready", o_axi_aw_ready, 1);
    @(negedge i_clk);
    i_axi_aw_valid = 0;
    // W
    for (int k = 0; k <= int'(v.len); k++) begin
      i_axi_w_valid = 1;
      i_axi_w_data  = v.seed * 64'(k + 1);
      i_axi_w_strb  = (k == 0) ? v.strb0 : v.strbn;
      i_axi_w_last  = v.early ? (k == 0) : (k == int'(v.len));
      t = 0;
      #1;
      while (!o_axi_w_ready && t < 50) begin @(negedge i_clk); #1; t++; end
      if (k == int'(v.len)) chk("b_before_w_done", o_axi_b_valid, 0);
      @(negedge i_clk);
    end
    i_axi_w_valid = 0; i_axi_w_last = 0;
    // B
    t = 0;
    while (!o_axi_b_valid && t < 50) begin @(negedge i_clk); t++; end
    chk("b_valid", o_axi_b_valid, 1);
    be = bq.pop_front();
    chk("b_resp", o_axi_b_resp, be.resp);
    chk("b_id", o_axi_b_id, be.id);
    i_axi_b_ready = 1;
    @(negedge i_clk);
    i_axi_b_ready = 0;
    chk("b_valid_end", o_axi_b_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  v;
    rexp_t e;
    //            wr addr           len    sz    burst  id    seed                    strb0  strbn  early tog  resp
    vecs[0]  = '{1, 32'h8000_0000, 8'd3,  3'd3, 2'b01, 4'd1, 64'hA5A5_0000_0000_0001, 8'hFF, 8'hFF, 0, 0, 2'b00};
    vecs[1]  = '{0, 32'h8000_0010, 8'd0,  3'd3, 2'b01, 4'd3, 64'd0,                   8'h00, 8'h00, 0, 0, 2'b00};
    vecs[2]  = '{1, 32'h8000_0008, 8'd1,  3'd3, 2'b01, 4'd5, 64'h1111_1111_1111_1111, 8'hFF, 8'h0F, 0, 0, 2'b00};
    vecs[3]  = '{0, 32'h8000_0008, 8'd1,  3'd3, 2'b01, 4'd5, 64'd0,                   8'h00, 8'h00, 0, 0, 2'b00};
    vecs[4]  = '{1, 32'h8000_0040, 8'd7,  3'd3, 2'b01, 4'd2, 64'h0123_4567_89AB_CDEF, 8'hFF, 8'hFF, 0, 0, 2'b00};
    vecs[5]  = '{0, 32'h8000_0018, 8'd1,  3'd3, 2'b10, 4'd6, 64'd0,                   8'h00, 8'h00, 0, 1, 2'b00};
    vecs[6]  = '{1, 32'h8000_7FF8, 8'd1,  3'd3, 2'b01, 4'd7, 64'hDEAD_BEEF_0000_0007, 8'hFF, 8'hFF, 0, 0, 2'b11};
    vecs[7]  = '{0, 32'h8000_7FF8, 8'd1,  3'd3, 2'b01, 4'd7, 64'd0,                   8'h00, 8'h00, 0, 0, 2'b00};
    vecs[8]  = '{1, 32'h8000_0020, 8'd1,  3'd3, 2'b01, 4'd8, 64'h5555_0000_AAAA_0001, 8'hFF, 8'hFF, 1, 0, 2'b10};
    vecs[9]  = '{0, 32'h8000_0020, 8'd1,  3'd3, 2'b01, 4'd8, 64'd0,                   8'h00, 8'h00, 0, 0, 2'b00};
    vecs[10] = '{1, 32'h8000_0010, 8'd2,  3'd3, 2'b10, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'hFF, 0, 0, 2'b10};
    vecs[11] = '{0, 32'h8000_0010, 8'd0,  3'd3, 2'b01, 4'd9, 64'd0,                   8'h00, 8'h00, 0, 0, 2'b00};
    vecs[12] = '{0, 32'h8000_0000, 8'd1,  3'd3, 2'b11, 4'd10, 64'd0,                  8'h00, 8'h00, 0, 0, 2'b00};
    vecs[13] = '{0, 32'h8000_0048, 8'd2,  3'd3, 2'b00, 4'd11, 64'd0,                  8'h00, 8'h00, 0, 0, 2'b00};
    vecs[14] = '{0, 32'h8000_0044, 8'd1,  3'd2, 2'b01, 4'd12, 64'd0,                  8'h00, 8'h00, 0, 1, 2'b00};
    vecs[15] = '{0, 32'h7FFF_FFF8, 8'd0,  3'd3, 2'b01, 4'd13, 64'd0,                  8'h00, 8'h00, 0, 0, 2'b00};
    vecs[16] = '{0, 32'h8000_0000, 8'd255, 3'd3, 2'b00, 4'd14, 64'd0,                 8'h00, 8'h00, 0, 0, 2'b00};
    vecs[17] = '{1, 32'h8000_0022, 8'd0,  3'd1, 2'b01, 4'd15, 64'h0000_0000_BEEF_0000, 8'h0C, 8'h0C, 0, 0, 2'b00};
    vecs[18] = '{0, 32'h8000_0020, 8'd0,  3'd3, 2'b01, 4'd15, 64'd0,                  8'h00, 8'h00, 0, 0, 2'b00};
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;

    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_ar_ready", o_axi_ar_ready, 0);
    chk("rst_aw_ready", o_axi_aw_ready, 0);
    chk("rst_w_ready", o_axi_w_ready, 0);
    chk("rst_b", {o_axi_b_valid, o_axi_b_resp, o_axi_b_id}, 0);
    chk("rst_r", {o_axi_r_valid, o_axi_r_resp, o_axi_r_last, o_axi_r_id}, 0);
    chk("rst_r_data", o_axi_r_data, 0);
    @(negedge i_clk);
    i_rst = 0;

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) run_write(vecs[i]);
      else            run_read(vecs[i]);
    end

    // AR and AW in the same IDLE cycle: read goes first, write waits for it to finish
    v = '{0, 32'h8000_0040, 8'd0, 3'd3, 2'b01, 4'd9, 64'd0, 8'h00, 8'h00, 0, 0, 2'b00};
    push_read(v);
    i_axi_ar_addr = v.addr; i_axi_ar_len = v.len; i_axi_ar_size = v.size;
    i_axi_ar_burst = v.burst; i_axi_ar_id = v.id; i_axi_ar_valid = 1;
    i_axi_aw_addr = 32'h8000_0058; i_axi_aw_len = 0; i_axi_aw_size = 3;
    i_axi_aw_burst = 2'b01; i_axi_aw_id = 4'd10; i_axi_aw_valid = 1;
    #1;
    chk("collide_aw_ready", o_axi_aw_ready, 0);
    chk("collide_ar_ready", o_axi_ar_ready, 1);
    @(negedge i_clk);
    i_axi_ar_valid = 0;
    #1;
    chk("collide_r_valid", o_axi_r_valid, 1);
    chk("collide_aw_in_rdata", o_axi_aw_ready, 0);
    r_phase(0);
    v = '{1, 32'h8000_0058, 8'd0, 3'd3, 2'b01, 4'd10, 64'h7777_7777_7777_7777, 8'hFF, 8'hFF, 0, 0, 2'b00};
    run_write(v);
    v = '{0, 32'h8000_0058, 8'd0, 3'd3, 2'b01, 4'd10, 64'd0, 8'h00, 8'h00, 0, 0, 2'b00};
    run_read(v);

    // Reset while beat 3 of an 8-beat read is on the bus
    v = '{0, 32'h8000_0040, 8'd7, 3'd3, 2'b01, 4'd4, 64'd0, 8'h00, 8'h00, 0, 0, 2'b00};
    push_read(v);
    ar_phase(v);
    for (int k = 0; k < 3; k++) begin
      i_axi_r_ready = 1;
      #1;
      e = rq.pop_front();
      chk("rstseq_r_data", o_axi_r_data, e.data);
      chk("rstseq_r_last", o_axi_r_last, e.last);
      @(negedge i_clk);
    end
    i_axi_r_ready = 0;
    i_rst = 1;
    #1;
    chk("rstseq_ar_ready_in_rst", o_axi_ar_ready, 0);
    @(negedge i_clk);
    chk("rstseq_r_valid", o_axi_r_valid, 0);
    chk("rstseq_r_last_cleared", o_axi_r_last, 0);
    chk("rstseq_r_data_cleared", o_axi_r_data, 0);
    i_rst = 0;
    rq.delete();
    #1;
    chk("rstseq_ar_ready_after", o_axi_ar_ready, 1);
    v = '{0, 32'h8000_0050, 8'd0, 3'd3, 2'b01, 4'd11, 64'd0, 8'h00, 8'h00, 0, 0, 2'b00};
    run_read(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 responder (slave) modelling a single-port 64-bit SRAM: the far end of the core's AXI4 master port.
- Accepts the master's single-beat and burst reads/writes (cache-line refills and write-backs of 2 beats, and uncached single beats).
- Serves as the memory model in the NPC simulation top and as an on-chip scratch RAM.
- Handles one transaction at a time.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width. Only 64 is supported.
- ID_W, 4, AXI ID width.
- MEM_DEPTH, 4096, number of 64-bit words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset
- i_axi_aw_valid in 1 / o_axi_aw_ready out 1  AW handshake
- i_axi_aw_addr in ADDR_W, i_axi_aw_id in ID_W, i_axi_aw_len in 8, i_axi_aw_size in 3, i_axi_aw_burst in 2  write address
- i_axi_w_valid in 1 / o_axi_w_ready out 1  W handshake
- i_axi_w_data in DATA_W, i_axi_w_strb in DATA_W/8, i_axi_w_last in 1  write data
- o_axi_b_valid out 1 / i_axi_b_ready in 1  B handshake
- o_axi_b_resp out 2, o_axi_b_id out ID_W  write response
- i_axi_ar_valid in 1 / o_axi_ar_ready out 1  AR handshake
- i_axi_ar_addr in ADDR_W, i_axi_ar_id in ID_W, i_axi_ar_len in 8, i_axi_ar_size in 3, i_axi_ar_burst in 2  read address
- o_axi_r_valid out 1 / i_axi_r_ready in 1  R handshake
- o_axi_r_data out DATA_W, o_axi_r_resp out 2, o_axi_r_last out 1, o_axi_r_id out ID_W  read data
- Interface: one clock; reset is synchronous and active-high.
- Master prot/lock/cache/qos/region/user signals are not connected. The integrator ties b_user/r_user to 0.

Behaviour:
- FSM states: IDLE, WDATA, WRESP, RDATA.
- Reset (i_rst high at a clock edge):
  - state goes to IDLE;
  - all valid/ready outputs, resp, id, data and last outputs are 0;
  - any in-flight transaction is dropped with no B or R beat issued;
  - memory contents are not cleared.
- IDLE:
  - o_axi_ar_ready = 1.
  - o_axi_aw_ready = !i_axi_ar_valid. Reads have priority when AR and AW are valid in the same cycle.
  - AR handshake latches id, addr, len, size and burst, then goes to RDATA.
  - AW handshake latches the same fields, then goes to WDATA.
- Beat address:
  - beat 0 = addr aligned down to 1<<size.
  - INCR (2'b01): each subsequent beat adds 1<<size.
  - FIXED (2'b00): the address is constant.
  - WRAP (2'b10): wraps within a boundary of (len+1)<<size. len must be 1, 3, 7 or 15.
  - Any other burst/len combination is unsupported: the whole transaction responds SLVERR (2'b10), no memory writes occur, and reads return 0.
  - size > 3 is also unsupported and treated the same way.
- Word index = (beat_addr - BASE_ADDR) >> 3.
  - A beat is in range iff BASE_ADDR <= beat_addr < BASE_ADDR + MEM_DEPTH*8.
  - The address is evaluated per beat.
- WDATA:
  - o_axi_w_ready = 1.
  - Each W handshake writes the bytes enabled by i_axi_w_strb into the word, if the beat is in range and the burst is supported. Data is taken on natural byte lanes.
  - The beat counter increments on each handshake.
  - After beat len is accepted, go to WRESP.
  - i_axi_w_last asserted on a beat other than beat len, or deasserted on beat len, sets an error flag. The transfer still ends on beat len.
- WRESP:
  - o_axi_b_valid = 1 and o_axi_b_id = the latched id.
  - resp priority: SLVERR if unsupported burst or last mismatch; else DECERR (2'b11) if any beat was out of range; else OKAY.
  - o_axi_b_valid is held until i_axi_b_ready, then go to IDLE. The next AW/AR may be accepted one cycle after the B handshake.
- RDATA:
  - The memory read is registered. The first R beat is valid in the cycle after the AR handshake.
  - o_axi_r_data/resp/last/id stay stable while r_valid && !r_ready.
  - On each R handshake the next beat is presented in the next cycle. Throughput is one beat per cycle with r_ready held high.
  - Per-beat r_resp: DECERR if the beat is out of range (data 0), SLVERR if the burst is unsupported (data 0), else OKAY.
  - o_axi_r_last = 1 on beat len only.
  - After the handshake of the last beat, r_valid falls and state goes to IDLE.
- Full 64-bit word is always returned for narrow reads. The master selects lanes.
- Beat counter is 8 bits. len = 255 gives 256 beats with no overflow.

Test Plan:
- Reset, then AR addr 0x8000_0010, len 0, size 3, INCR, id 3 -> r_valid in the next cycle, data = mem[2], resp OKAY, last 1, id 3. All outputs are 0 during reset.
- AW 0x8000_0008 len 1 INCR id 5; W beats 0x1111..., then 0x2222... with strb 0x0F and last on beat 1 -> mem[1]=0x1111_1111_1111_1111, mem[2] low word=0x2222_2222, B OKAY id 5, only after both beats.
- AR and AW valid in the same IDLE cycle -> AR accepted first and aw_ready=0 that cycle; AW accepted after the read completes.
- AR WRAP len 1 size 3 addr 0x8000_0018 -> beats from words 3 then 2. With r_ready toggling 1/0, each beat is held stable while r_ready is low and no beat is skipped.
- AW addr BASE+MEM_DEPTH*8-8 len 1 INCR -> beat 0 is written, beat 1 is dropped, B resp DECERR. W with last early on beat 0 of len 1 -> B SLVERR.
- i_rst asserted mid RDATA (len 7, beat 3) -> r_valid is 0 the next cycle, state is IDLE, and a new AR is accepted immediately after reset deasserts.
